// File: rtl/decode_rr_arbiter_pkg.sv
// Shared constants and the rotating-priority search for decode_rr_arbiter.
package decode_rr_arbiter_pkg;

   localparam int unsigned NREQ  = 16;
   localparam int unsigned IDX_W = 4;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GRANT = 2'd1;
   localparam logic [1:0] GAP   = 2'd2;

   // First set bit of req scanning upward from last+1; the last index is checked last.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] req,
                                                input logic [IDX_W-1:0] last);
      logic             found;
      logic [IDX_W-1:0] idx;
      logic [IDX_W-1:0] win;
      found = 1'b0;
      win   = last;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         idx = last + IDX_W'(k);
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/decode_rr_arbiter_decode416.sv
// 4-to-16 one-hot decoder with enable; all outputs low when disabled.
module decode416 (
   input  logic [3:0]  x,
   input  logic        en,
   output logic [15:0] y
);

   always_comb begin
      y = '0;
      if (en) y[x] = 1'b1;
   end

endmodule

// File: rtl/decode_rr_arbiter.sv
// Round-robin arbiter sharing one decode416 among 16 requesters, with a
// dead cycle between owners and an optional hold timeout.
module decode_rr_arbiter
   import decode_rr_arbiter_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 8,
   parameter int unsigned CNT_W    = 4
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic [NREQ-1:0]  req,
   output logic [IDX_W-1:0] x,
   output logic             en,
   output logic [NREQ-1:0]  gnt,
   output logic             busy,
   output logic             timeout
);

   logic [1:0]       r_state,   w_state;
   logic [IDX_W-1:0] r_x,       w_x;
   logic             r_en,      w_en;
   logic [IDX_W-1:0] r_last,    w_last;
   logic [CNT_W-1:0] r_hold,    w_hold;
   logic             r_timeout, w_timeout;
   logic             r_busy,    w_busy;
   logic [IDX_W-1:0] w_win;
   logic             w_hold_hit;

   assign w_win      = rr_pick(req, r_last);
   assign w_hold_hit = (MAX_HOLD != 0) && (r_hold == CNT_W'(MAX_HOLD - 1));

   // Next-state and registered-output logic.
   always_comb begin
      w_state   = r_state;
      w_x       = r_x;
      w_en      = r_en;
      w_last    = r_last;
      w_hold    = r_hold;
      w_timeout = 1'b0;
      case (r_state)
         IDLE, GAP: begin
            if (|req) begin
               w_x     = w_win;
               w_en    = 1'b1;
               w_hold  = '0;
               w_state = GRANT;
            end else begin
               w_en    = 1'b0;
               w_state = IDLE;
            end
         end
         GRANT: begin
            if (!req[r_x]) begin
               w_en    = 1'b0;
               w_last  = r_x;
               w_state = GAP;
            end else if (w_hold_hit) begin
               w_en      = 1'b0;
               w_last    = r_x;
               w_timeout = 1'b1;
               w_state   = GAP;
            end else if (r_hold != {CNT_W{1'b1}}) begin
               w_hold = r_hold + CNT_W'(1);
            end
         end
         default: begin
            w_en    = 1'b0;
            w_state = IDLE;
         end
      endcase
      w_busy = (w_state == GRANT) || (w_state == GAP);
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_state   <= IDLE;
         r_x       <= '0;
         r_en      <= 1'b0;
         r_last    <= IDX_W'(NREQ - 1);
         r_hold    <= '0;
         r_timeout <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_x       <= w_x;
         r_en      <= w_en;
         r_last    <= w_last;
         r_hold    <= w_hold;
         r_timeout <= w_timeout;
         r_busy    <= w_busy;
      end
   end

   decode416 u_dec (
      .x  (r_x),
      .en (r_en),
      .y  (gnt)
   );

   assign x       = r_x;
   assign en      = r_en;
   assign busy    = r_busy;
   assign timeout = r_timeout;

endmodule

// File: tb/tb_decode_rr_arbiter.sv
// Directed and randomized checks of decode_rr_arbiter against a behavioural model.
module tb_decode_rr_arbiter;

   localparam int MAX_HOLD = 8;

   logic        clk;
   logic        clrn;
   logic [15:0] req;
   logic [3:0]  x;
   logic        en;
   logic [15:0] gnt;
   logic        busy;
   logic        timeout;

   int checks = 0;
   int errors = 0;

   // Behavioural model: phase 0 = nobody owns, 1 = owned, 2 = dead cycle
   int m_phase, m_owner, m_last, m_age;
   bit m_to;

   decode_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
      .clk     (clk),
      .clrn    (clrn),
      .req     (req),
      .x       (x),
      .en      (en),
      .gnt     (gnt),
      .busy    (busy),
      .timeout (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int pick(input logic [15:0] r, input int last);
      for (int k = 1; k <= 16; k++)
         if (r[(last + k) % 16]) return (last + k) % 16;
      return -1;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_owner = 0; m_last = 15; m_age = 0; m_to = 0;
   endtask

   task automatic model_step(input logic [15:0] r);
      m_to = 0;
      if (m_phase == 1) begin
         if (!r[m_owner]) begin
            m_last = m_owner; m_phase = 2;
         end else if (MAX_HOLD > 0 && m_age == MAX_HOLD) begin
            m_last = m_owner; m_phase = 2; m_to = 1;
         end else m_age++;
      end else if (r != 16'h0) begin
         m_owner = pick(r, m_last); m_age = 1; m_phase = 1;
      end else m_phase = 0;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      logic [15:0] eg;
      eg = (m_phase == 1) ? (16'h1 << m_owner) : 16'h0;
      chk("x",       16'(x),       16'(m_owner));
      chk("en",      16'(en),      16'(m_phase == 1));
      chk("gnt",     gnt,          eg);
      chk("busy",    16'(busy),    16'(m_phase != 0));
      chk("timeout", 16'(timeout), 16'(m_to));
   endtask

   // Drive req from a negedge, let one rising edge pass, check at the next negedge.
   task automatic cycle(input logic [15:0] r);
      req = r;
      model_step(r);
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset();
      clrn = 1'b0;
      req  = 16'h0;
      model_reset();
      @(negedge clk);
      check_all();
      clrn = 1'b1;
   endtask

   initial begin
      logic [15:0] r;
      int          exp_k;
      clrn = 1'b0;
      req  = 16'h0;
      model_reset();
      #2;
      check_all();
      do_reset();

      // Idle after reset
      for (int i = 0; i < 5; i++) cycle(16'h0);

      // Single requester: grant, release, dead cycle, idle
      cycle(16'h0010);
      chk("single_gnt", gnt, 16'h0010);
      cycle(16'h0010);
      cycle(16'h0000);
      chk("single_gap_gnt", gnt, 16'h0000);
      chk("single_gap_busy", 16'(busy), 16'h1);
      cycle(16'h0000);
      chk("single_idle_busy", 16'(busy), 16'h0);

      // All requesting, owner drops right after grant: strict rotation
      do_reset();
      exp_k = 0;
      cycle(16'hFFFF);
      for (int g = 0; g < 17; g++) begin
         chk("rot_x", 16'(x), 16'(exp_k));
         chk("rot_gnt", gnt, 16'h1 << exp_k);
         cycle(~gnt);
         chk("rot_gap", gnt, 16'h0);
         cycle(16'hFFFF);
         exp_k = (exp_k + 1) % 16;
      end

      // Hold timeout with two steady requesters
      do_reset();
      for (int i = 0; i < MAX_HOLD; i++) begin
         cycle(16'h0003);
         chk("to_hold0", gnt, 16'h0001);
      end
      cycle(16'h0003);
      chk("to_pulse", 16'(timeout), 16'h1);
      chk("to_gap", gnt, 16'h0);
      for (int i = 0; i < MAX_HOLD; i++) begin
         cycle(16'h0003);
         chk("to_hold1", gnt, 16'h0002);
         chk("to_clear", 16'(timeout), 16'h0);
      end
      cycle(16'h0003);
      cycle(16'h0003);
      chk("to_back0", gnt, 16'h0001);

      // Sole requester re-granted after every release
      do_reset();
      cycle(16'h0100);
      for (int i = 0; i < 4; i++) begin
         chk("sole_gnt", gnt, 16'h0100);
         cycle(16'h0000);
         cycle(16'h0100);
      end

      // Asynchronous reset mid-grant
      do_reset();
      cycle(16'h0400);
      cycle(16'h0400);
      chk("pre_rst_gnt", gnt, 16'h0400);
      #2 clrn = 1'b0;
      #1;
      model_reset();
      chk("async_gnt", gnt, 16'h0);
      chk("async_en", 16'(en), 16'h0);
      check_all();
      @(negedge clk);
      clrn = 1'b1;
      cycle(16'h0401);
      chk("post_rst_gnt", gnt, 16'h0001);

      // Randomized traffic, sometimes holding the owner's bit to hit timeouts
      do_reset();
      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(0, 3))
            0: r = 16'($urandom);
            1: r = 16'($urandom) & 16'($urandom) & 16'($urandom);
            2: r = (m_phase == 1) ? (16'($urandom) | (16'h1 << m_owner)) : 16'($urandom_range(0, 3));
            default: r = 16'h0;
         endcase
         cycle(r);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
